regfile_wb_arbiter: RTL

Shares the single register-file write port (`RuWr`/`rd`/`RuWrData`) between two writeback requesters: requester 0 is ALU/execute and requester 1 is the load/multi-cycle unit. It holds a 32-entry pending-write scoreboard. The decode stage uses it to stall on RAW and WAW hazards. It sits between execute/memory writeback and the register unit.

---
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, plus a pending-write scoreboard for decode hazards.
// Optional macro RU_WB_BYPASS_EN forwards the write-edge data to decode and suppresses the matching hazard.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int RAW_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [RAW_W-1:0] issue_rd,
  output logic             issue_ready,
  input  logic [RAW_W-1:0] rs1,
  input  logic [RAW_W-1:0] rs2,
  output logic             hazard1,
  output logic             hazard2,
  output logic             fwd1_valid,
  output logic             fwd2_valid,
  output logic [XLEN-1:0]  fwd1_data,
  output logic [XLEN-1:0]  fwd2_data,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [RAW_W-1:0] req0_rd,
  input  logic [RAW_W-1:0] req1_rd,
  input  logic [XLEN-1:0]  req0_data,
  input  logic [XLEN-1:0]  req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             wb_we,
  output logic [RAW_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [31:0]      pending
);

  logic             last_r;
  logic             grant0_s;
  logic             grant1_s;
  logic [RAW_W-1:0] win_rd_s;
  logic [XLEN-1:0]  win_data_s;
  logic             wb_we_r;
  logic [RAW_W-1:0] wb_rd_r;
  logic [XLEN-1:0]  wb_data_r;
  logic [31:0]      pending_r;
  logic [31:0]      pending_nxt_s;
  logic             issue_ready_s;
  logic             issue_fire_s;
  logic             fwd1_s;
  logic             fwd2_s;
  logic             raw1_s;
  logic             raw2_s;

  // Grant selection: a lone requester wins; under contention the one not granted last time wins
  always_comb begin
    grant0_s   = 1'b0;
    grant1_s   = 1'b0;
    win_rd_s   = req1_rd;
    win_data_s = req1_data;
    if (req0_valid && (!req1_valid || last_r)) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
    if (grant0_s) begin
      win_rd_s   = req0_rd;
      win_data_s = req0_data;
    end else begin
      win_rd_s   = req1_rd;
      win_data_s = req1_data;
    end
  end

  // Round-robin pointer and registered write port; x0 writes are consumed but never raise wb_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r    <= 1'b1;
      wb_we_r   <= 1'b0;
      wb_rd_r   <= {RAW_W{1'b0}};
      wb_data_r <= {XLEN{1'b0}};
    end else if (grant0_s || grant1_s) begin
      last_r    <= grant1_s;
      wb_we_r   <= (win_rd_s != {RAW_W{1'b0}});
      wb_rd_r   <= win_rd_s;
      wb_data_r <= win_data_s;
    end else begin
      wb_we_r   <= 1'b0;
    end
  end

  // Issue may proceed if the destination is free, being written back this cycle, or x0
  always_comb begin
    issue_ready_s = !pending_r[issue_rd] || (wb_we_r && (wb_rd_r == issue_rd)) ||
                    (issue_rd == {RAW_W{1'b0}});
    issue_fire_s  = issue_valid && issue_ready_s;
  end

  // Scoreboard next state: clear on the write edge, then set so a same-edge reissue wins
  always_comb begin
    pending_nxt_s = pending_r;
    if (wb_we_r) begin
      pending_nxt_s[wb_rd_r] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (issue_fire_s && (issue_rd != {RAW_W{1'b0}})) begin
      pending_nxt_s[issue_rd] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 32'h0000_0000;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Source hazard detection with optional same-cycle bypass of the write-port data
  always_comb begin
    raw1_s = pending_r[rs1] && (rs1 != {RAW_W{1'b0}});
    raw2_s = pending_r[rs2] && (rs2 != {RAW_W{1'b0}});
`ifdef RU_WB_BYPASS_EN
    fwd1_s = wb_we_r && (wb_rd_r == rs1) && (rs1 != {RAW_W{1'b0}});
    fwd2_s = wb_we_r && (wb_rd_r == rs2) && (rs2 != {RAW_W{1'b0}});
`else
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
`endif
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign issue_ready = issue_ready_s;
  assign hazard1     = raw1_s && !fwd1_s;
  assign hazard2     = raw2_s && !fwd2_s;
  assign fwd1_valid  = fwd1_s;
  assign fwd2_valid  = fwd2_s;
  assign fwd1_data   = fwd1_s ? wb_data_r : {XLEN{1'b0}};
  assign fwd2_data   = fwd2_s ? wb_data_r : {XLEN{1'b0}};
  assign wb_we       = wb_we_r;
  assign wb_rd       = wb_rd_r;
  assign wb_data     = wb_data_r;
  assign pending     = pending_r;

endmodule
